// File: rtl/csr_counter_unit_if.sv
// CSR access bus between core decode (master) and csr_counter_unit (slave).
// Single-cycle strobes in; registered read data, valid and error pulses out.
interface csr_counter_unit_if #(
    parameter int XLEN = 32
) ();
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;
    logic            csr_re;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_rvalid;
    logic            csr_err;

    modport master (
        output csr_addr, csr_wdata, csr_we, csr_re,
        input  csr_rdata, csr_rvalid, csr_err
    );

    modport slave (
        input  csr_addr, csr_wdata, csr_we, csr_re,
        output csr_rdata, csr_rvalid, csr_err
    );
endinterface

// File: rtl/csr_counter_unit.sv
// Machine counter/timer CSR bank: mcycle, minstret, hpm counters, mcountinhibit, prescaled mtime.
// Define CSR_HPM_OVF_IRQ_EN to add mhpmovf (0x7C4) and ovf_irq. Note: resetn is active-high.
module csr_counter_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_HPM  = 4,
    parameter int EVENT_W  = 8,
    parameter int TIME_DIV = 1
) (
    input  logic               clk,
    input  logic               resetn,
    csr_counter_unit_if.slave  bus,
    input  logic               instret_pulse,
    input  logic [EVENT_W-1:0] event_in,
    output logic               timer_irq,
    output logic               ovf_irq
);
    localparam int NCNT = 3 + NUM_HPM;
    localparam int NEVT = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int PW   = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [31:0] INH_MASK = 32'((64'd1 << NCNT) - 64'd1) & ~32'h2;

    // Counter slot 1 is unused and constant, keeping slot index equal to the CSR offset.
    logic [63:0]     r_cnt [NCNT];
    logic [XLEN-1:0] r_evt [NEVT];
    logic [31:0]     r_inhibit;
    logic [63:0]     r_mtime, r_mtimecmp;
    logic [PW-1:0]   r_presc;
    logic [XLEN-1:0] r_rdata;
    logic            r_rvalid, r_err, r_timer_irq;
`ifdef CSR_HPM_OVF_IRQ_EN
    logic [31:0]     r_ovf, w_ovf_nxt;
    logic            r_ovf_irq, w_ovf_we;
`endif

    logic [63:0]     w_cnt_nxt [NCNT];
    logic [NCNT-1:0] w_cnt_we_lo, w_cnt_we_hi, w_inc;
    logic [NEVT-1:0] w_evt_we;
    logic            w_inh_we, w_time_we_lo, w_time_we_hi, w_cmp_we_lo, w_cmp_we_hi;
    logic            w_mapped, w_ro, w_tick;
    logic [XLEN-1:0] w_rd_data;
    logic [63:0]     w_mtime_nxt, w_mtimecmp_nxt;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [XLEN-1:0] wd,
                                          input logic lo, input logic hi);
        logic [63:0] m;
        m = old;
        if (XLEN == 64) begin
            if (lo) m = 64'(wd);
        end else begin
            if (lo) m[31:0]  = wd[31:0];
            if (hi) m[63:32] = wd[31:0];
        end
        return m;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so partial decode never infers a latch.
        w_rd_data    = '0;
        w_mapped     = 1'b0;
        w_ro         = 1'b0;
        w_cnt_we_lo  = '0;
        w_cnt_we_hi  = '0;
        w_evt_we     = '0;
        w_inh_we     = 1'b0;
        w_time_we_lo = 1'b0;
        w_time_we_hi = 1'b0;
        w_cmp_we_lo  = 1'b0;
        w_cmp_we_hi  = 1'b0;
`ifdef CSR_HPM_OVF_IRQ_EN
        w_ovf_we     = 1'b0;
`endif
        for (int c = 0; c < NCNT; c++) begin
            if (c != 1) begin
                if (bus.csr_addr == 12'hB00 + 12'(c)) begin
                    w_mapped = 1'b1; w_rd_data = r_cnt[c][XLEN-1:0]; w_cnt_we_lo[c] = bus.csr_we;
                end
                if (bus.csr_addr == 12'hC00 + 12'(c)) begin
                    w_mapped = 1'b1; w_ro = 1'b1; w_rd_data = r_cnt[c][XLEN-1:0];
                end
                if (XLEN == 32) begin
                    if (bus.csr_addr == 12'hB80 + 12'(c)) begin
                        w_mapped = 1'b1; w_rd_data = XLEN'(r_cnt[c][63:32]); w_cnt_we_hi[c] = bus.csr_we;
                    end
                    if (bus.csr_addr == 12'hC80 + 12'(c)) begin
                        w_mapped = 1'b1; w_ro = 1'b1; w_rd_data = XLEN'(r_cnt[c][63:32]);
                    end
                end
            end
        end
        if (bus.csr_addr == 12'h320) begin
            w_mapped = 1'b1; w_rd_data = XLEN'(r_inhibit); w_inh_we = bus.csr_we;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (bus.csr_addr == 12'h323 + 12'(i)) begin
                w_mapped = 1'b1; w_rd_data = r_evt[i]; w_evt_we[i] = bus.csr_we;
            end
        end
        if (bus.csr_addr == 12'h7C0) begin
            w_mapped = 1'b1; w_rd_data = r_mtime[XLEN-1:0]; w_time_we_lo = bus.csr_we;
        end
        if (bus.csr_addr == 12'h7C2) begin
            w_mapped = 1'b1; w_rd_data = r_mtimecmp[XLEN-1:0]; w_cmp_we_lo = bus.csr_we;
        end
        if (XLEN == 32 && bus.csr_addr == 12'h7C1) begin
            w_mapped = 1'b1; w_rd_data = XLEN'(r_mtime[63:32]); w_time_we_hi = bus.csr_we;
        end
        if (XLEN == 32 && bus.csr_addr == 12'h7C3) begin
            w_mapped = 1'b1; w_rd_data = XLEN'(r_mtimecmp[63:32]); w_cmp_we_hi = bus.csr_we;
        end
`ifdef CSR_HPM_OVF_IRQ_EN
        if (bus.csr_addr == 12'h7C4) begin
            w_mapped = 1'b1; w_rd_data = XLEN'(r_ovf); w_ovf_we = bus.csr_we;
        end
`endif
    end

    // A CSR write to a counter takes priority over that cycle's increment.
    always_comb begin
        w_inc    = '0;
        w_inc[0] = !r_inhibit[0];
        w_inc[2] = instret_pulse && !r_inhibit[2];
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int e = 0; e < EVENT_W; e++) begin
                if (r_evt[i] == XLEN'(e + 1) && event_in[e] && !r_inhibit[3 + i]) w_inc[3 + i] = 1'b1;
            end
        end
        for (int c = 0; c < NCNT; c++) begin
            if (w_cnt_we_lo[c] || w_cnt_we_hi[c])
                w_cnt_nxt[c] = merge(r_cnt[c], bus.csr_wdata, w_cnt_we_lo[c], w_cnt_we_hi[c]);
            else if (w_inc[c])
                w_cnt_nxt[c] = r_cnt[c] + 64'd1;
            else
                w_cnt_nxt[c] = r_cnt[c];
        end
        w_tick = (r_presc == PW'(TIME_DIV - 1));
        if (w_time_we_lo || w_time_we_hi)
            w_mtime_nxt = merge(r_mtime, bus.csr_wdata, w_time_we_lo, w_time_we_hi);
        else if (w_tick)
            w_mtime_nxt = r_mtime + 64'd1;
        else
            w_mtime_nxt = r_mtime;
        w_mtimecmp_nxt = merge(r_mtimecmp, bus.csr_wdata, w_cmp_we_lo, w_cmp_we_hi);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            // NOTE: these arrays are flops, not RAM, so each element is cleared on reset.
            for (int c = 0; c < NCNT; c++) r_cnt[c] <= '0;
            for (int i = 0; i < NEVT; i++) r_evt[i] <= '0;
            r_inhibit   <= '0;
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_presc     <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_timer_irq <= 1'b0;
        end else begin
            for (int c = 0; c < NCNT; c++) r_cnt[c] <= w_cnt_nxt[c];
            for (int i = 0; i < NUM_HPM; i++) begin
                if (w_evt_we[i]) r_evt[i] <= bus.csr_wdata;
            end
            if (w_inh_we) r_inhibit <= bus.csr_wdata[31:0] & INH_MASK;
            r_mtime     <= w_mtime_nxt;
            r_mtimecmp  <= w_mtimecmp_nxt;
            r_presc     <= w_tick ? '0 : r_presc + 1'b1;
            r_timer_irq <= (r_mtime >= r_mtimecmp);
            r_rvalid    <= bus.csr_re;
            r_err       <= (bus.csr_re && !w_mapped) || (bus.csr_we && (!w_mapped || w_ro));
            if (bus.csr_re) r_rdata <= w_rd_data;
        end
    end

`ifdef CSR_HPM_OVF_IRQ_EN
    // A wrap sets its bit after the W1C clear is applied, so the set wins on collision.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_ovf_we) w_ovf_nxt = r_ovf & ~bus.csr_wdata[31:0];
        for (int i = 0; i < NUM_HPM; i++) begin
            if (w_inc[3 + i] && !w_cnt_we_lo[3 + i] && !w_cnt_we_hi[3 + i] && (&r_cnt[3 + i]))
                w_ovf_nxt[3 + i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_ovf     <= '0;
            r_ovf_irq <= 1'b0;
        end else begin
            r_ovf     <= w_ovf_nxt;
            r_ovf_irq <= |r_ovf;
        end
    end

    assign ovf_irq = r_ovf_irq;
`else
    assign ovf_irq = 1'b0;
`endif

    assign bus.csr_rdata  = r_rdata;
    assign bus.csr_rvalid = r_rvalid;
    assign bus.csr_err    = r_err;
    assign timer_irq      = r_timer_irq;
endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit (XLEN=32, NUM_HPM=4, EVENT_W=8, TIME_DIV=4).
// Inputs change just after a falling edge; outputs are sampled on the following falling edge.
module tb_csr_counter_unit;
    localparam int XLEN     = 32;
    localparam int NUM_HPM  = 4;
    localparam int EVENT_W  = 8;
    localparam int TIME_DIV = 4;

    logic               clk = 1'b0;
    logic               resetn = 1'b1;
    logic               instret_pulse = 1'b0;
    logic [EVENT_W-1:0] event_in = '0;
    logic               timer_irq, ovf_irq;
    int                 n_checks = 0;
    int                 n_pass = 0;

    csr_counter_unit_if #(.XLEN(XLEN)) bus ();

    csr_counter_unit #(
        .XLEN(XLEN), .NUM_HPM(NUM_HPM), .EVENT_W(EVENT_W), .TIME_DIV(TIME_DIV)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .instret_pulse(instret_pulse),
        .event_in(event_in), .timer_irq(timer_irq), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Returns on the falling edge where reset is released; no active edge has passed yet.
    task automatic do_reset();
        bus.csr_addr = '0; bus.csr_wdata = '0; bus.csr_we = 1'b0; bus.csr_re = 1'b0;
        instret_pulse = 1'b0; event_in = '0;
        tick();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [XLEN-1:0] data);
        bus.csr_addr = addr; bus.csr_wdata = data; bus.csr_we = 1'b1;
        tick();
        bus.csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr);
        bus.csr_addr = addr; bus.csr_re = 1'b1;
        tick();
        bus.csr_re = 1'b0;
    endtask

    task automatic expect_rd(input string name, input logic [XLEN-1:0] exp);
        n_checks++;
        if (bus.csr_rdata !== exp || bus.csr_rvalid !== 1'b1)
            $display("FAIL %s: rdata=%0h rvalid=%b, expected rdata=%0h rvalid=1", name, bus.csr_rdata, bus.csr_rvalid, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.csr_rdata, bus.csr_rvalid, bus.csr_err, timer_irq, ovf_irq} !== '0)
            $display("FAIL reset_outputs: rdata=%0h rvalid=%b err=%b tirq=%b oirq=%b, expected all 0",
                     bus.csr_rdata, bus.csr_rvalid, bus.csr_err, timer_irq, ovf_irq);
        else n_pass++;
        csr_read(12'h7C3);
        expect_rd("reset_mtimecmp_hi", 32'hFFFF_FFFF);
        csr_read(12'h320);
        expect_rd("reset_mcountinhibit", 32'h0);
    endtask

    task automatic test_mcycle_read();
        do_reset();
        idle(10);
        csr_read(12'hB00);
        expect_rd("mcycle_after_10", 32'd10);
        n_checks++;
        if (bus.csr_err !== 1'b0) $display("FAIL mcycle_err: got %b expected 0", bus.csr_err);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.csr_rvalid !== 1'b0 || bus.csr_rdata !== 32'd10)
            $display("FAIL rvalid_pulse_hold: rvalid=%b rdata=%0h, expected rvalid=0 rdata=a", bus.csr_rvalid, bus.csr_rdata);
        else n_pass++;
    endtask

    task automatic test_wrap();
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'h0);
        idle(1);
        csr_read(12'hB80);
        expect_rd("mcycle_carry_hi", 32'd1);
        csr_read(12'hB00);
        expect_rd("mcycle_after_carry_lo", 32'd1);
        csr_write(12'hB00, 32'h100);
        csr_read(12'hB00);
        expect_rd("write_beats_increment", 32'h100);
        bus.csr_addr = 12'hB00; bus.csr_wdata = 32'h50; bus.csr_we = 1'b1; bus.csr_re = 1'b1;
        tick();
        bus.csr_we = 1'b0; bus.csr_re = 1'b0;
        expect_rd("read_write_same_cycle", 32'h101);
        csr_read(12'hB00);
        expect_rd("write_applied", 32'h50);
        csr_read(12'hB80);
        expect_rd("hi_half_kept", 32'd1);
    endtask

    task automatic test_hpm();
        csr_write(12'h323, 32'd2);
        event_in = 8'h02; idle(5);
        event_in = 8'h01; idle(3);
        event_in = 8'h00;
        csr_read(12'hB03);
        expect_rd("hpm3_event2", 32'd5);
        csr_read(12'hC03);
        expect_rd("hpm3_user_alias", 32'd5);
        n_checks++;
        if (bus.csr_err !== 1'b0) $display("FAIL alias_read_err: got %b expected 0", bus.csr_err);
        else n_pass++;
        csr_read(12'hB04);
        expect_rd("hpm4_event0_idle", 32'd0);
        instret_pulse = 1'b1; idle(3); instret_pulse = 1'b0;
        csr_read(12'hB02);
        expect_rd("minstret_3", 32'd3);
        csr_write(12'h320, 32'h8);
        csr_write(12'h324, 32'd9);
        event_in = 8'hFF; idle(4); event_in = 8'h00;
        csr_read(12'hB03);
        expect_rd("hpm3_inhibited", 32'd5);
        csr_read(12'hB04);
        expect_rd("hpm4_event_above_width", 32'd0);
        csr_write(12'h320, 32'hFFFF_FFFF);
        csr_read(12'h320);
        expect_rd("mcountinhibit_mask", 32'h7D);
        instret_pulse = 1'b1; idle(2); instret_pulse = 1'b0;
        csr_read(12'hB02);
        expect_rd("minstret_inhibited", 32'd3);
    endtask

    task automatic test_err();
        csr_write(12'hB00, 32'h77);
        csr_write(12'hC00, 32'h1234);
        n_checks++;
        if (bus.csr_err !== 1'b1) $display("FAIL write_ro_err: got %b expected 1", bus.csr_err);
        else n_pass++;
        csr_read(12'hB00);
        expect_rd("mcycle_unchanged_by_ro_write", 32'h77);
        n_checks++;
        if (bus.csr_err !== 1'b0) $display("FAIL err_pulse_cleared: got %b expected 0", bus.csr_err);
        else n_pass++;
        csr_read(12'h7FF);
        expect_rd("unmapped_read_data", 32'h0);
        n_checks++;
        if (bus.csr_err !== 1'b1) $display("FAIL unmapped_read_err: got %b expected 1", bus.csr_err);
        else n_pass++;
        csr_write(12'hB01, 32'h5);
        n_checks++;
        if (bus.csr_err !== 1'b1) $display("FAIL unmapped_write_err: got %b expected 1", bus.csr_err);
        else n_pass++;
    endtask

    task automatic test_timer();
        do_reset();
        csr_write(12'h7C3, 32'h0);
        csr_write(12'h7C2, 32'd3);
        idle(10);
        n_checks++;
        if (timer_irq !== 1'b0) $display("FAIL timer_irq_at_12: got %b expected 0", timer_irq);
        else n_pass++;
        idle(1);
        n_checks++;
        if (timer_irq !== 1'b1) $display("FAIL timer_irq_at_13: got %b expected 1", timer_irq);
        else n_pass++;
        csr_write(12'h7C2, 32'd100);
        idle(1);
        n_checks++;
        if (timer_irq !== 1'b0) $display("FAIL timer_irq_clear: got %b expected 0", timer_irq);
        else n_pass++;
        csr_read(12'h7C0);
        expect_rd("mtime_prescaled", 32'd3);
    endtask

    task automatic test_reset_mid();
        bus.csr_addr = 12'hB00; bus.csr_re = 1'b1;
        #2 resetn = 1'b1;
        tick();
        bus.csr_re = 1'b0;
        n_checks++;
        if (bus.csr_rvalid !== 1'b0 || bus.csr_rdata !== 32'h0)
            $display("FAIL reset_mid_read: rvalid=%b rdata=%0h, expected 0 0", bus.csr_rvalid, bus.csr_rdata);
        else n_pass++;
        resetn = 1'b0;
    endtask

    task automatic test_ovf();
        do_reset();
`ifdef CSR_HPM_OVF_IRQ_EN
        csr_write(12'h323, 32'd1);
        csr_write(12'hB03, 32'hFFFF_FFFF);
        csr_write(12'hB83, 32'hFFFF_FFFF);
        event_in = 8'h01; tick(); event_in = 8'h00;
        csr_read(12'h7C4);
        expect_rd("mhpmovf_set", 32'h8);
        n_checks++;
        if (ovf_irq !== 1'b1) $display("FAIL ovf_irq_set: got %b expected 1", ovf_irq);
        else n_pass++;
        csr_read(12'hB83);
        expect_rd("hpm3_wrapped_hi", 32'h0);
        csr_write(12'h7C4, 32'h8);
        idle(1);
        n_checks++;
        if (ovf_irq !== 1'b0) $display("FAIL ovf_irq_clear: got %b expected 0", ovf_irq);
        else n_pass++;
        csr_read(12'h7C4);
        expect_rd("mhpmovf_clear", 32'h0);
`else
        csr_read(12'h7C4);
        n_checks++;
        if (bus.csr_err !== 1'b1 || ovf_irq !== 1'b0)
            $display("FAIL ovf_disabled: err=%b ovf_irq=%b, expected err=1 ovf_irq=0", bus.csr_err, ovf_irq);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_mcycle_read();
        test_wrap();
        test_hpm();
        test_err();
        test_timer();
        test_reset_mid();
        test_ovf();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1);
    end
endmodule

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Parametrised machine counter/timer CSR block for the riskproc core.
- Replaces the fixed cycle, instret and timer counters in the CSR file with one configurable bank:
  - mcycle and minstret
  - NUM_HPM event-selectable hpm counters
  - mcountinhibit
  - prescaled mtime with mtimecmp and a timer interrupt
- Sits beside the CSR file. The core decode routes counter-range CSR accesses here; rdata is muxed back onto the CSR read bus.

Parameters:
- XLEN, 32, data width; 32 or 64. At 32, every 64-bit counter is split into low/high CSRs.
- NUM_HPM, 4, number of hpm counters (mhpmcounter3..3+NUM_HPM-1); range 0..29.
- EVENT_W, 8, width of the event_in bus.
- TIME_DIV, 1, mtime increments once every TIME_DIV clk cycles; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous reset, active-high. Asserting it high resets all state immediately.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write data.
- csr_we  in  1  write strobe, single cycle.
- csr_re  in  1  read strobe, single cycle.
- csr_rdata  out  XLEN  registered read data.
- csr_rvalid  out  1  one-cycle pulse; csr_rdata is valid in that cycle.
- csr_err  out  1  one-cycle pulse. Set for an unmapped address, or a write to a read-only address.
- instret_pulse  in  1  one retired instruction this cycle.
- event_in  in  EVENT_W  per-cycle event pulses for the hpm counters.
- timer_irq  out  1  machine timer interrupt pending (MTIP).

Behaviour:
- Address map:
  - 0xB00 mcycle; 0xB02 minstret; 0xB03+i mhpmcounter(3+i).
  - 0xB80/0xB82/0xB83+i: high halves; mapped only when XLEN=32.
  - 0xC00/0xC02/0xC03+i (and 0xC80.. when XLEN=32): read-only user aliases.
  - 0x320 mcountinhibit; 0x323+i mhpmevent(3+i).
  - 0x7C0/0x7C1 mtime lo/hi; 0x7C2/0x7C3 mtimecmp lo/hi. At XLEN=64, 0x7C0 and 0x7C2 hold the full value; 0x7C1 and 0x7C3 are unmapped.
- Reset values:
  - All counters, mtime, mcountinhibit, mhpmevent: 0.
  - mtimecmp: all ones.
  - Prescaler: 0.
  - csr_rdata, csr_rvalid, csr_err, timer_irq: 0.
- Read:
  - csr_re in cycle N: csr_rdata is the value held at cycle N (before that cycle's increment), presented at N+1 with csr_rvalid high.
  - Unmapped address: csr_rdata=0, csr_err=1 at N+1.
  - csr_rdata holds its value until the next read.
- Write:
  - csr_we in cycle N: the target updates at the end of N, with the value visible from N+1.
  - A write to a read-only alias or unmapped address: csr_err pulses at N+1; no state change.
  - csr_we and csr_re together: the read returns the pre-write value and the write still applies.
- Counting, evaluated each cycle:
  - mcycle +1 unless mcountinhibit[0].
  - minstret +instret_pulse unless mcountinhibit[2].
  - hpm i +1 when event_in[k-1]=1, where k=mhpmevent(3+i), 1<=k<=EVENT_W, and mcountinhibit[3+i]=0. k=0 or k>EVENT_W never counts.
  - mcountinhibit[1] and bits above 2+NUM_HPM are hardwired to 0.
- Width and wrap:
  - Counters and mtime are 64-bit unsigned and wrap from all ones to 0.
  - With XLEN=32, the low half carries into the high half.
- Write versus increment in the same cycle:
  - The write wins; that counter does not increment that cycle.
  - When writing one half, the other half keeps its old value.
- Timer:
  - The prescaler counts 0..TIME_DIV-1. mtime increments in the cycle the prescaler equals TIME_DIV-1, and the prescaler wraps to 0.
  - Writing mtime does not reset the prescaler.
  - timer_irq is registered: it equals (mtime >= mtimecmp, unsigned 64-bit) evaluated on the previous cycle's values. It is therefore one cycle late relative to an mtime or mtimecmp change.
  - Writing mtimecmp to a value above mtime clears timer_irq within 2 cycles.
- Reset mid-operation: all state returns to reset values immediately. A pending read does not produce csr_rvalid.

Optional Feature:
- Macro: CSR_HPM_OVF_IRQ_EN.
- With the macro defined:
  - Adds output ovf_irq (1 bit) and CSR 0x7C4 mhpmovf. Bit 3+i is set when hpm counter i wraps from all ones to 0.
  - A write of 1 to a bit clears it (W1C). If a wrap and a clear of the same bit coincide, the set wins.
  - ovf_irq is the OR of all mhpmovf bits, registered. Reset value: 0.
- Without it: ovf_irq is tied to 0 and 0x7C4 is unmapped (csr_err pulses on access).

Test Plan:
- Reset, then 10 idle cycles, then read 0xB00 -> csr_rdata=10 one cycle after csr_re; csr_rvalid pulses once; csr_err=0.
- XLEN=32, write 0xB00=0xFFFFFFFF then 0xB80=0, run 2 cycles, then read 0xB80 -> 1. Write and increment in the same cycle -> the written value is held and no increment occurs that cycle.
- Write mhpmevent3=2, pulse event_in[1] 5 times and event_in[0] 3 times, then read 0xB03 -> 5. Set mcountinhibit[3]=1, pulse event_in[1] 4 more times -> still 5.
- TIME_DIV=4, mtimecmp=3 -> timer_irq rises 13 cycles after reset (mtime reaches 3 after 12 cycles, plus one registered cycle). Write mtimecmp=100 -> timer_irq=0 within 2 cycles.
- Write 0xC00 -> csr_err=1 and mcycle unchanged. Read 0x7FF -> csr_rdata=0 and csr_err=1.
- With CSR_HPM_OVF_IRQ_EN, mhpmcounter3 = all ones and event enabled, one event -> counter=0, mhpmovf[3]=1, ovf_irq=1 next cycle. Write 0x7C4=0x8 -> both clear.
